// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_INIT,
    RF_RUN
  } rf_state_t;

  // Low bit of port idx inside a flattened multi-port bus.
  function automatic int slice_lo(int idx, int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_init_ctrl.sv
// Post-reset clear sequencer: walks every register once, then opens the file for writes.
//
// state   | meaning
// --------+------------------------------------------------
// RF_IDLE | just reset, nothing cleared yet
// RF_INIT | clearing reg[init_ptr], one register per cycle
// RF_RUN  | array cleared, writes accepted (terminal)
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  rf_state_t         state;
  logic [ADDR_W-1:0] init_ptr;

  assign clr_addr = init_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RF_IDLE;
      init_ptr  <= '0;
      clr_en    <= 1'b0;
      ready     <= 1'b0;
      init_busy <= 1'b0;
    end else begin
      case (state)
        RF_IDLE: begin
          state     <= RF_INIT;
          init_ptr  <= '0;
          clr_en    <= 1'b1;
          init_busy <= 1'b1;
        end
        RF_INIT: begin
          if (init_ptr == LAST_PTR) begin
            state     <= RF_RUN;
            clr_en    <= 1'b0;
            init_busy <= 1'b0;
            ready     <= 1'b1;
          end else begin
            init_ptr <= init_ptr + 1'b1;
          end
        end
        RF_RUN: begin
          state <= RF_RUN;
        end
        default: begin
          state     <= RF_IDLE;
          init_ptr  <= '0;
          clr_en    <= 1'b0;
          ready     <= 1'b0;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read, dual-write register file with hardware clear after reset.
// Optional write-first forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  output logic                     ready,
  output logic                     init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr0_ok;
  logic              wr1_ok;

  regfile_init_ctrl #(.ADDR_W(ADDR_W)) u_init_ctrl (
    .clk       (clk),
    .reset     (reset),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr),
    .ready     (ready),
    .init_busy (init_busy)
  );

  assign wr0_ok = ready && wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
  assign wr1_ok = ready && wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));

  // wr0 is dropped explicitly on a same-address collision so priority never
  // depends on NBA ordering.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wr0_ok && !(wr1_ok && (wr1_addr == wr0_addr)))
        mem[wr0_addr] <= wr0_data;
      if (wr1_ok)
        mem[wr1_addr] <= wr1_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];

    always_comb begin
      data = '0;
      if (ready && !((ZERO_REG != 0) && (addr == '0))) begin
`ifdef REGFILE_BYPASS_EN
        if (wr1_en && (wr1_addr == addr))
          data = wr1_data;
        else if (wr0_en && (wr0_addr == addr))
          data = wr0_data;
        else
          data = mem[addr];
`else
        data = mem[addr];
`endif
      end
    end

    assign rd_data[slice_lo(i, DATA_W) +: DATA_W] = data;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: one instance with ZERO_REG=0, one with ZERO_REG=1,
// both driven by the same stimulus and compared against an array-based reference model.
module tb_register_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data, rd_data_z;
  logic              wr0_en, wr1_en;
  logic [AW-1:0]     wr0_addr, wr1_addr;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic              ready, init_busy, ready_z, init_busy_z;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem   [DEPTH];
  logic [DW-1:0] ref_mem_z [DEPTH];
  int            edges = 0;   // clock edges since the last reset edge (saturating)

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .ready(ready), .init_busy(init_busy)
  );

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_z),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .ready(ready_z), .init_busy(init_busy_z)
  );

  function automatic bit ref_ready();
    return edges >= DEPTH + 1;
  endfunction

  function automatic bit ref_busy();
    return (edges >= 1) && (edges <= DEPTH);
  endfunction

  function automatic logic [DW-1:0] exp_rd(int port, bit zero);
    logic [AW-1:0] a;
    a = rd_addr[port*AW +: AW];
    if (!ref_ready()) return '0;
    if (zero && (a == '0)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr1_en && (wr1_addr == a)) return wr1_data;
    if (wr0_en && (wr0_addr == a)) return wr0_data;
`endif
    return zero ? ref_mem_z[a] : ref_mem[a];
  endfunction

  // One clock edge: update the model from the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      edges = 0;
    end else begin
      if (ref_ready()) begin
        if (wr0_en) ref_mem[wr0_addr] = wr0_data;
        if (wr1_en) ref_mem[wr1_addr] = wr1_data;
        if (wr0_en && wr0_addr != '0) ref_mem_z[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != '0) ref_mem_z[wr1_addr] = wr1_data;
      end
      if (edges <= DEPTH) begin
        edges++;
        if (edges == DEPTH + 1) begin
          for (int r = 0; r < DEPTH; r++) begin
            ref_mem[r]   = '0;
            ref_mem_z[r] = '0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    wr0_en = 1'b0; wr1_en = 1'b0;
    wr0_addr = '0; wr1_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  // Compare status outputs and every read port of both instances with the model.
  task automatic compare_all(string tag);
    #1;
    checks++;
    if (ready !== ref_ready() || ready_z !== ref_ready()) begin
      errors++;
      $display("FAIL %s ready: got %b/%b expected %b", tag, ready, ready_z, ref_ready());
    end
    checks++;
    if (init_busy !== ref_busy() || init_busy_z !== ref_busy()) begin
      errors++;
      $display("FAIL %s init_busy: got %b/%b expected %b", tag, init_busy, init_busy_z, ref_busy());
    end
    for (int p = 0; p < NR; p++) begin
      checks++;
      if (rd_data[p*DW +: DW] !== exp_rd(p, 1'b0)) begin
        errors++;
        $display("FAIL %s rd port %0d addr %0d: got %h expected %h", tag, p,
                 rd_addr[p*AW +: AW], rd_data[p*DW +: DW], exp_rd(p, 1'b0));
      end
      checks++;
      if (rd_data_z[p*DW +: DW] !== exp_rd(p, 1'b1)) begin
        errors++;
        $display("FAIL %s zero-reg rd port %0d addr %0d: got %h expected %h", tag, p,
                 rd_addr[p*AW +: AW], rd_data_z[p*DW +: DW], exp_rd(p, 1'b1));
      end
    end
  endtask

  task automatic read_all_regs(string tag);
    idle_inputs();
    for (int k = 0; k < DEPTH; k += 2) begin
      rd_addr = {AW'(k + 1), AW'(k)};
      compare_all(tag);
    end
  endtask

  task automatic run_init(string tag, bit wr_attempts);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      if (wr_attempts) begin
        wr0_en = 1'b1; wr0_addr = AW'($urandom_range(0, DEPTH - 1)); wr0_data = $urandom;
      end
      rd_addr = {AW'($urandom), AW'($urandom)};
      tick();
      compare_all(tag);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_addr = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ready !== 1'b0 || init_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b init_busy=%b expected 0/0", ready, init_busy);
    end
    run_init("init", 1'b0);
    read_all_regs("cleared");
  endtask

  task automatic test_write_read();
    for (int k = 0; k < DEPTH; k++) begin
      wr0_en = 1'b1; wr0_addr = AW'(k); wr0_data = DW'(10 * k);
      tick();
    end
    idle_inputs();
    for (int k = 0; k < DEPTH; k++) begin
      rd_addr = {AW'(k + 1), AW'(k)};
      compare_all("write_read");
      checks++;
      if (rd_data[0 +: DW] !== DW'(10 * k)) begin
        errors++;
        $display("FAIL write_read reg %0d: got %h expected %h", k, rd_data[0 +: DW], DW'(10 * k));
      end
    end
  endtask

  task automatic test_collision();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hAAAA_AAAA;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h5555_5555;
    tick();
    idle_inputs();
    rd_addr = {5'd7, 5'd7};
    compare_all("collision");
    checks++;
    if (rd_data[DW +: DW] !== 32'h5555_5555) begin
      errors++;
      $display("FAIL collision reg7: got %h expected 55555555", rd_data[DW +: DW]);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] old_val;
    old_val = ref_mem[3];
    rd_addr = {5'd9, 5'd3};
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h1234;
    compare_all("bypass_same_cycle");
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (rd_data[0 +: DW] !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h expected 00001234", rd_data[0 +: DW]);
    end
`else
    if (rd_data[0 +: DW] !== old_val) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h expected %h", rd_data[0 +: DW], old_val);
    end
`endif
    tick();
    idle_inputs();
    compare_all("bypass_next_cycle");
    checks++;
    if (rd_data[0 +: DW] !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_next_cycle: got %h expected 00001234", rd_data[0 +: DW]);
    end
  endtask

  task automatic test_zero_reg();
    rd_addr = '0;
    wr0_en = 1'b1; wr0_addr = '0; wr0_data = 32'hFFFF_FFFF;
    compare_all("zero_write_cycle");
    checks++;
    if (rd_data_z !== '0) begin
      errors++;
      $display("FAIL zero_write_cycle: got %h expected 0", rd_data_z);
    end
    tick();
    idle_inputs();
    compare_all("zero_after");
    checks++;
    if (rd_data_z !== '0) begin
      errors++;
      $display("FAIL zero_after: got %h expected 0", rd_data_z);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr0_en = 1'($urandom); wr0_addr = AW'($urandom); wr0_data = $urandom;
      wr1_en = 1'($urandom); wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom);
      wr1_data = $urandom;
      rd_addr = {($urandom_range(0, 3) == 0) ? wr1_addr : AW'($urandom),
                 ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom)};
      compare_all("random");
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_init();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'd99;
    tick();
    idle_inputs();
    rd_addr = {5'd5, 5'd5};
    compare_all("preload");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      compare_all("partial_init");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compare_all("reset_mid_init");
    run_init("reinit", 1'b1);
    rd_addr = {5'd5, 5'd5};
    compare_all("reg5_cleared");
    checks++;
    if (rd_data[0 +: DW] !== '0) begin
      errors++;
      $display("FAIL reg5_cleared: got %h expected 0", rd_data[0 +: DW]);
    end
    read_all_regs("reinit_cleared");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_bypass();
    test_zero_reg();
    test_random();
    test_reset_mid_init();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
